// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter access controller: operation codes and FSM states.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    NOP  = 2'b00,
    LOAD = 2'b01,
    INC  = 2'b10,
    DEC  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after the pointer,
// wrapping around. The pointer register is owned by the instantiating block.
module rr_arbiter #(
  parameter int unsigned R = 4
) (
  input  logic [R-1:0]         req,
  input  logic [$clog2(R)-1:0] pointer,
  input  logic                 enable,
  output logic [R-1:0]         gnt,
  output logic [$clog2(R)-1:0] gnt_idx
);

  localparam int unsigned IdW = $clog2(R);

  logic            found;
  logic [31:0]     cand;
  logic [IdW-1:0]  cand_idx;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int unsigned i = 0; i < R; i++) begin
      cand     = (32'(pointer) + 32'(i)) % 32'(R);
      cand_idx = cand[IdW-1:0];
      if (enable && !found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/counter_access_ctrl.sv
// Shares one load/inc/dec counter among R requesters: round-robin grant, one-cycle strobe,
// then a tagged response carrying the post-operation count and a saturation error flag.
module counter_access_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned R = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [R-1:0]         req_valid,
  input  logic [2*R-1:0]       req_op,
  input  logic [R*N-1:0]       req_data,
  output logic [R-1:0]         req_ready,
  output logic                 rsp_valid,
  output logic [$clog2(R)-1:0] rsp_id,
  output logic [N-1:0]         rsp_count,
  output logic                 rsp_err,
  output logic                 cnt_load,
  output logic                 cnt_inc,
  output logic                 cnt_dec,
  output logic [N-1:0]         cnt_din,
  input  logic [N-1:0]         cnt_count
);

  localparam int unsigned IdW = $clog2(R);

  state_e         state_q, state_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] id_q;
  op_e            op_q;
  logic [N-1:0]   din_q;
  logic           err_q;

  logic [R-1:0]   gnt;
  logic [IdW-1:0] gnt_idx;
  logic           any_gnt;
  logic           arb_en;
  op_e            sel_op;
  logic [N-1:0]   sel_data;
  logic           issue;
  logic           is_err;

  // Gate on reset_n so no grant is visible while reset is held.
  assign arb_en = reset_n && (state_q == IDLE);

  rr_arbiter #(
    .R(R)
  ) u_rr_arbiter (
    .req    (req_valid),
    .pointer(ptr_q),
    .enable (arb_en),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign any_gnt   = |gnt;
  assign req_ready = gnt;
  assign sel_op    = op_e'(req_op[2*gnt_idx +: 2]);
  assign sel_data  = req_data[N*gnt_idx +: N];
  assign ptr_d     = (gnt_idx == IdW'(R - 1)) ? '0 : gnt_idx + IdW'(1);

  always_comb begin
    if (reset_n && any_gnt) begin
      assert (!$isunknown(req_valid) && !$isunknown(sel_op))
        else $error("counter_access_ctrl: unknown op or valid in granted slot");
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_gnt) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      id_q  <= '0;
      op_q  <= NOP;
      din_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (any_gnt) begin
        ptr_q <= ptr_d;
        id_q  <= gnt_idx;
        op_q  <= sel_op;
        // Load data only changes on a LOAD so cnt_din stays put across other ops.
        if (sel_op == LOAD) din_q <= sel_data;
      end
      if (issue) err_q <= is_err;
    end
  end

  assign issue  = (state_q == ISSUE);
  assign is_err = ((op_q == INC) && (cnt_count == '1)) || ((op_q == DEC) && (cnt_count == '0));

  assign cnt_load = issue && (op_q == LOAD);
  assign cnt_inc  = issue && (op_q == INC) && !is_err;
  assign cnt_dec  = issue && (op_q == DEC) && !is_err;
  assign cnt_din  = din_q;

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_valid ? id_q : '0;
  assign rsp_count = rsp_valid ? cnt_count : '0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_counter_access_ctrl.sv
// Bench for counter_access_ctrl: directed scenarios plus random traffic, checked against a
// transaction-level model (RR pick, saturating counter arithmetic, fixed response timing).
module tb_counter_access_ctrl;
  import counter_ctrl_pkg::*;

  localparam int unsigned N   = 8;
  localparam int unsigned R   = 4;
  localparam int unsigned IdW = 2;

  logic             clk       = 1'b0;
  logic             reset_n   = 1'b0;
  logic             cnt_rst_n = 1'b0;
  logic [R-1:0]     req_valid = '0;
  logic [2*R-1:0]   req_op    = '0;
  logic [R*N-1:0]   req_data  = '0;
  logic [R-1:0]     req_ready;
  logic             rsp_valid;
  logic [IdW-1:0]   rsp_id;
  logic [N-1:0]     rsp_count;
  logic             rsp_err;
  logic             cnt_load, cnt_inc, cnt_dec;
  logic [N-1:0]     cnt_din;
  logic [N-1:0]     tb_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int           cyc       = 0;
  int           next_free = 0;
  int           ptr       = 0;
  int           strb_cyc  = -1;
  int           rsp_cyc   = -1;
  int           last_w    = -1;
  logic [2:0]   exp_strb  = '0;  // {load, inc, dec}
  int           exp_id    = 0;
  logic [N-1:0] exp_cnt   = '0;
  logic         exp_err   = 1'b0;
  logic [N-1:0] exp_din   = '0;
  logic [N-1:0] ref_cnt   = 8'h33;

  always #5 clk = ~clk;

  counter_access_ctrl #(
    .N(N),
    .R(R)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_count(rsp_count),
    .rsp_err  (rsp_err),
    .cnt_load (cnt_load),
    .cnt_inc  (cnt_inc),
    .cnt_dec  (cnt_dec),
    .cnt_din  (cnt_din),
    .cnt_count(tb_cnt)
  );

  // Counter instance attached to the strobes; deliberately not reset by the DUT reset.
  always @(posedge clk) begin
    if (!cnt_rst_n)    tb_cnt <= 8'h33;
    else if (cnt_load) tb_cnt <= cnt_din;
    else if (cnt_inc)  tb_cnt <= tb_cnt + 8'd1;
    else if (cnt_dec)  tb_cnt <= tb_cnt - 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic run_cycle(input logic [R-1:0] v, input logic [2*R-1:0] ops,
                           input logic [R*N-1:0] dat);
    int           w;
    op_e          op;
    logic [N-1:0] d;
    logic         er;
    @(negedge clk);
    req_valid = v;
    req_op    = ops;
    req_data  = dat;
    #1;
    w = -1;
    if (cyc >= next_free) begin
      for (int k = 0; k < int'(R); k++) begin
        int c;
        c = (ptr + k) % int'(R);
        if (w < 0 && v[c]) w = c;
      end
    end
    check("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
    check("strobes", 32'({cnt_load, cnt_inc, cnt_dec}), (cyc == strb_cyc) ? 32'(exp_strb) : 32'd0);
    check("cnt_din", 32'(cnt_din), 32'(exp_din));
    if (cyc == rsp_cyc) begin
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_id", 32'(rsp_id), 32'(exp_id));
      check("rsp_count", 32'(rsp_count), 32'(exp_cnt));
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
    end else begin
      check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    end
    last_w = w;
    if (w >= 0) begin
      op       = op_e'(ops[2*w +: 2]);
      d        = dat[N*w +: N];
      er       = ((op == INC) && (ref_cnt == 8'hFF)) || ((op == DEC) && (ref_cnt == 8'h00));
      exp_strb = '0;
      if (!er) begin
        case (op)
          LOAD:    begin exp_strb = 3'b100; ref_cnt = d; end
          INC:     begin exp_strb = 3'b010; ref_cnt = ref_cnt + 8'd1; end
          DEC:     begin exp_strb = 3'b001; ref_cnt = ref_cnt - 8'd1; end
          default: exp_strb = 3'b000;
        endcase
      end
      if (op == LOAD) exp_din = d;
      exp_id    = w;
      exp_cnt   = ref_cnt;
      exp_err   = er;
      strb_cyc  = cyc + 1;
      rsp_cyc   = cyc + 2;
      next_free = cyc + 3;
      ptr       = (w + 1) % int'(R);
    end
    cyc++;
  endtask

  // One request from a single requester, then idle until the response has gone by.
  task automatic post(input int id, input op_e op, input logic [N-1:0] d);
    logic [2*R-1:0] ops;
    logic [R*N-1:0] dat;
    ops = '0;
    dat = '0;
    ops[2*id +: 2] = op;
    dat[N*id +: N] = d;
    run_cycle(R'(1) << id, ops, dat);
    run_cycle('0, ops, dat);
    run_cycle('0, ops, dat);
  endtask

  initial begin
    logic [R-1:0]   cur_v;
    logic [2*R-1:0] cur_op;
    logic [R*N-1:0] cur_dat;
    logic [N-1:0]   keep;
    logic [N-1:0]   d;

    // Reset: grant must be masked even with every requester valid.
    @(negedge clk);
    cnt_rst_n = 1'b1;
    req_valid = '1;
    req_op    = 8'b01010101;
    req_data  = 32'hA5A5A5A5;
    @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_count", 32'(rsp_count), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_strobes", 32'({cnt_load, cnt_inc, cnt_dec}), 32'd0);
    check("rst_cnt_din", 32'(cnt_din), 32'd0);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // Single LOAD, saturation guard, zero guard
    post(0, LOAD, 8'h5A);
    post(1, LOAD, 8'hFF);
    post(2, INC, 8'h00);
    post(0, LOAD, 8'h00);
    post(3, DEC, 8'h00);
    post(1, NOP, 8'h77);
    // Leaves the pointer at 0 with count 0 for the fairness run.
    post(3, LOAD, 8'h00);

    // Fairness: all four hold INC continuously.
    for (int t = 0; t < 15; t++) run_cycle('1, 8'b10101010, 32'h01020304);
    run_cycle('0, '0, '0);
    run_cycle('0, '0, '0);

    // Reset during ISSUE of an INC aborts it.
    post(1, LOAD, 8'h10);
    keep = ref_cnt;
    run_cycle(4'b0100, 8'b10101010, '0);
    @(negedge clk);
    req_valid = '0;
    reset_n   = 1'b0;
    #1;
    check("abort_strobes", 32'({cnt_load, cnt_inc, cnt_dec}), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    check("abort_rsp_valid2", 32'(rsp_valid), 32'd0);
    check("abort_count", 32'(tb_cnt), 32'(keep));
    reset_n   = 1'b1;
    cyc       = cyc + 2;
    ptr       = 0;
    next_free = cyc;
    strb_cyc  = -1;
    rsp_cyc   = -1;
    exp_din   = '0;
    ref_cnt   = keep;
    last_w    = -1;

    // Random traffic; requesters hold op/data while waiting, sometimes withdraw.
    cur_v   = '0;
    cur_op  = '0;
    cur_dat = '0;
    for (int t = 0; t < 600; t++) begin
      for (int k = 0; k < int'(R); k++) begin
        if (cur_v[k] && k != last_w) begin
          if ($urandom_range(9) == 0) cur_v[k] = 1'b0;
        end else begin
          cur_v[k] = ($urandom_range(2) == 0);
          cur_op[2*k +: 2] = 2'($urandom_range(3));
          case ($urandom_range(3))
            0:       d = 8'h00;
            1:       d = 8'hFF;
            default: d = 8'($urandom);
          endcase
          cur_dat[N*k +: N] = d;
        end
      end
      run_cycle(cur_v, cur_op, cur_dat);
    end
    run_cycle('0, '0, '0);
    run_cycle('0, '0, '0);
    run_cycle('0, '0, '0);
    check("final_count", 32'(tb_cnt), 32'(ref_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
